pb_irq_controller: RTL

Interrupt controller for the PicoBlaze (KCPSM6) processor in the record/playback design. It collects up to eight edge-triggered requests (sample tick, button events, memory-done, and similar) into pending and mask registers. It drives the CPU's single `interrupt` line with fixed priority and retires each request through the `interrupt_ack` strobe plus an end-of-interrupt (EOI) port write. It sits beside the CPU wrapper on the `port_id` / `out_port` / `in_port` bus, and the top level ORs its read data into `in_port`.

---
 rtl/pb_irq_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pb_irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pb_irq_controller                                                          |
// | Fixed-priority edge-triggered interrupt controller for a KCPSM6 port bus.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pb_irq_controller #(
   parameter int         N_SRC     = 4,
   parameter logic [7:0] BASE_PORT = 8'h40
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [7:0]       port_id,
   input  logic             write_strobe,
   input  logic [7:0]       out_port,
   output logic [7:0]       rd_data,
   output logic             rd_hit,
   output logic             interrupt,
   input  logic             interrupt_ack
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   localparam logic [5:0]       c_base_hi = BASE_PORT[7:2];
   localparam logic [N_SRC-1:0] c_one     = 1;

   state_t           r_state;
   logic [N_SRC-1:0] r_src_q;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_mask;
   logic [2:0]       r_svc_vec;
   logic             r_interrupt;
   logic             r_in_service;
   logic [7:0]       r_rd_data;
   logic             r_rd_hit;

   logic             w_hit;
   logic             w_wr_mask;
   logic             w_wr_clr;
   logic             w_wr_eoi;
   logic             w_ack;
   logic [N_SRC-1:0] w_active;
   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] w_clr;
   logic [N_SRC-1:0] w_ack_clr;
   logic [2:0]       w_vec;
   logic [7:0]       w_rd_mux;
   logic             w_unused;

   assign w_hit     = (port_id[7:2] == c_base_hi);
   assign w_wr_mask = write_strobe && w_hit && (port_id[1:0] == 2'd1);
   assign w_wr_clr  = write_strobe && w_hit && (port_id[1:0] == 2'd2);
   assign w_wr_eoi  = write_strobe && w_hit && (port_id[1:0] == 2'd3);
   assign w_unused  = &{1'b0, out_port, BASE_PORT[1:0]};

   assign w_active  = r_pending & r_mask;
   assign w_rise    = irq_src & ~r_src_q;
   assign w_ack     = (r_state == ST_ASSERT) && interrupt_ack;
   assign w_clr     = w_wr_clr ? out_port[N_SRC-1:0] : '0;
   assign w_ack_clr = (w_ack && (w_active != '0)) ? (c_one << w_vec) : '0;

   // Lowest active index wins; scan from the top so the last hit is the lowest.
   always_comb begin
      w_vec = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            w_vec = 3'(i);
         end
      end
   end

   always_comb begin
      w_rd_mux = 8'h00;
      case (port_id[1:0])
         2'd0: w_rd_mux = 8'(r_pending);
         2'd1: w_rd_mux = 8'(r_mask);
         2'd2: w_rd_mux = 8'(w_active);
         2'd3: w_rd_mux = {r_in_service, 4'b0000,
                           (r_state == ST_SERVICE) ? r_svc_vec : w_vec};
         default: w_rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_src_q   <= '0;
         r_pending <= '0;
         r_mask    <= '0;
         r_rd_data <= 8'h00;
         r_rd_hit  <= 1'b0;
      end else begin
         r_src_q   <= irq_src;
         // A new edge outranks any clear landing on the same bit.
         r_pending <= (r_pending & ~w_clr & ~w_ack_clr) | w_rise;
         if (w_wr_mask) begin
            r_mask <= out_port[N_SRC-1:0];
         end
         r_rd_hit  <= w_hit;
         r_rd_data <= w_hit ? w_rd_mux : 8'h00;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_svc_vec    <= 3'd0;
         r_interrupt  <= 1'b0;
         r_in_service <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_active != '0) begin
                  r_state     <= ST_ASSERT;
                  r_interrupt <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (interrupt_ack) begin
                  r_state      <= ST_SERVICE;
                  r_svc_vec    <= w_vec;
                  r_interrupt  <= 1'b0;
                  r_in_service <= 1'b1;
               end else if (w_active == '0) begin
                  r_state     <= ST_IDLE;
                  r_interrupt <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (w_wr_eoi) begin
                  r_state      <= ST_IDLE;
                  r_in_service <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_interrupt  <= 1'b0;
               r_in_service <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_hit    = r_rd_hit;
   assign interrupt = r_interrupt;

endmodule
`default_nettype wire
